// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ = 3;
   localparam int REQ_IDX_W   = $clog2(DEF_NUM_REQ);
   localparam int ZERO_REG    = 0;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority pick: first valid requester after the last grant, wrapping.
module rr_priority_select #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin
      int   w_cand;
      logic w_found;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_cand = (int'(i_last_grant) + off) % NUM_REQ;
         if (!w_found && i_valid[w_cand]) begin
            o_grant[w_cand] = 1'b1;
            o_idx           = IDX_W'(w_cand);
            w_found         = 1'b1;
         end
      end
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Shares the register-file write port among requesters round-robin and
// runs a clear sequence that zeroes r1..r(NUM_REGS-1).
module reg_file_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      clear_i,
   output logic                      busy_o,
   output logic                      clear_done_o,
   output logic                      rf_we_o,
   output logic [ADDR_W-1:0]         rf_addr_o,
   output logic [DATA_W-1:0]         rf_data_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic [IDX_W-1:0]    r_last_grant;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_addr_ok;
   logic                w_transfer;
   logic                w_cnt_last;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_select (
      .i_valid      (req_valid_i),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_idx        (w_idx),
      .o_any        (w_any)
   );

   assign w_sel_addr = req_addr_i[w_idx*ADDR_W +: ADDR_W];
   assign w_sel_data = req_data_i[w_idx*DATA_W +: DATA_W];
   assign w_addr_ok  = (int'(w_sel_addr) != ZERO_REG) && (int'(w_sel_addr) < NUM_REGS);
   assign w_transfer = (r_state == IDLE) && !clear_i && w_any;
   assign w_cnt_last = (r_cnt == ADDR_W'(NUM_REGS - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (clear_i) w_next_state = CLEAR;
         CLEAR:   if (w_cnt_last) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Ready is gated by reset so nothing looks accepted while the block is held.
   always_comb begin
      req_ready_o  = '0;
      busy_o       = (r_state != IDLE);
      clear_done_o = (r_state == DONE);
      if (rst_i && (r_state == IDLE) && !clear_i) req_ready_o = w_grant;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt        <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clear_i) begin
                  r_cnt <= ADDR_W'(1);
               end else if (w_transfer) begin
                  r_last_grant <= w_idx;
                  if (w_addr_ok) begin
                     r_we   <= 1'b1;
                     r_addr <= w_sel_addr;
                     r_data <= w_sel_data;
                  end
               end
            end
            CLEAR: begin
               r_we   <= 1'b1;
               r_addr <= r_cnt;
               r_data <= '0;
               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rf_we_o   = r_we;
   assign rf_addr_o = r_addr;
   assign rf_data_o = r_data;

endmodule

// File: doc/reg_file_write_arbiter.md
Name: reg_file_write_arbiter

Overview:
Shares the single write port of the CPU register file (`Reg_File`, 32 x 32-bit) between NUM_REQ requesters: CPU writeback, load unit and debug/test loader. Requesters are served round-robin through valid/ready handshakes, and the port is driven from registered outputs. An embedded clear sequencer zeroes r1..r(NUM_REGS-1) on request, so the bench can start from a known register state. The block sits between the requesters and the `RF` write inputs of `Simple_Single_CPU`.

Parameters:
NUM_REQ, 3, number of write requesters (>=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of architected registers (<= 2**ADDR_W)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low (0 = reset)
req_valid_i  in  NUM_REQ  per-requester write request
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_data_i  in  NUM_REQ*DATA_W  packed data, requester k at [k*DATA_W +: DATA_W]
req_ready_o  out  NUM_REQ  one-hot grant/accept
clear_i  in  1  start clear sequence (level sampled in IDLE)
busy_o  out  1  clear sequence in progress
clear_done_o  out  1  one-cycle pulse at end of clear
rf_we_o  out  1  register file write enable (registered)
rf_addr_o  out  ADDR_W  register file write address (registered)
rf_data_o  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (rst_i=0, async): state=IDLE, cnt=0, last_grant=NUM_REQ-1, rf_we_o=0, rf_addr_o=0, rf_data_o=0, busy_o=0, clear_done_o=0. req_ready_o reads 0.
- Transfer on requester k: req_valid_i[k] && req_ready_o[k]. Requesters hold valid/addr/data stable until accepted.
- req_ready_o is combinational. It is asserted only in IDLE with clear_i=0. It is one-hot on the first valid requester searching from last_grant+1 mod NUM_REQ, upward with wrap. It is all-zero when no requester is valid.
- IDLE guarantees at most one transfer per cycle and exactly one when any valid is high. On a transfer, last_grant <= k.
- Latency is 1 cycle: the edge ending the transfer cycle loads rf_we_o=1, rf_addr_o=addr_k and rf_data_o=data_k. With no transfer, rf_we_o<=0 and addr/data hold.
- addr==0 or addr>=NUM_REGS: the request is accepted (ready high, pointer advances) and dropped, so rf_we_o<=0.
- States:
  - IDLE: clear_i=1 -> CLEAR with cnt<=1. clear_i beats any valid that cycle: no ready.
  - CLEAR: each edge loads rf_we_o=1, rf_addr_o=cnt, rf_data_o=0 and increments cnt. When cnt==NUM_REGS-1, the state goes to DONE. busy_o=1. All ready signals are 0. clear_i is ignored.
  - DONE: busy_o=1, clear_done_o=1, ready all 0, rf_we_o<=0. The next state is IDLE.
- Clear writes NUM_REGS-1 registers on consecutive cycles; r0 is never written.
- busy_o and clear_done_o are decoded from the state register, so they are glitch-free.
- Reset mid-clear aborts immediately: outputs and state return to reset values, and nothing resumes after release.
- The round-robin pointer is not changed by clear.

Decomposition:
- Shared package `rf_arb_pkg`:
  - state enum: IDLE, CLEAR, DONE.
  - localparam REQ_IDX_W = $clog2(NUM_REQ).
  - address constant ZERO_REG = 0.
- Natural sub-module `rr_priority_select`: combinational. Takes valid vector and last_grant; produces one-hot grant and encoded index.
- The top level holds the FSM, cnt, pointer and output registers.

Test Plan:
1. Release reset; req_valid_i=3'b010, addr1=5, data1=32'hA5 for one cycle -> req_ready_o=3'b010 that cycle; next cycle rf_we_o=1, rf_addr_o=5, rf_data_o=32'hA5; the cycle after, rf_we_o=0.
2. All three valid continuously, addrs 1/2/3, each requester dropping valid after its own accept and re-raising it one cycle later -> accept order 0,1,2,0,1,2; one rf_we_o pulse per cycle with addrs 1,2,3,1,2,3.
3. Requester 2 writes addr 0, data 32'hFFFF -> req_ready_o[2]=1; rf_we_o stays 0; the next arbitration starts from requester 0.
4. clear_i=1 and req_valid_i[0]=1 (addr 4) in the same IDLE cycle -> ready 0 for 32 cycles. rf_we_o pulses on addrs 1..31 with data 0 over 31 consecutive cycles, busy_o=1 throughout, and clear_done_o pulses once. Requester 0 is accepted in the first IDLE cycle after; rf_addr_o=4 one cycle later.
5. Drive rst_i=0 asynchronously while rf_addr_o=10 during clear -> rf_we_o, busy_o and rf_addr_o are 0 before the next edge. After release: state IDLE, no further clear writes, requester 0 has highest priority.
6. Integrated in `Simple_Single_CPU` with `RF` preloaded nonzero, pulse clear_i -> bench dump of r0..r12 prints all zeros; a subsequent program run matches the golden CO_P2_Result.txt.
